// File: rtl/hex_keypad_pkg.sv
// Shared types and constants for the 4x4 hex keypad scanner.
package hex_keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int CODE_W   = 4;

    localparam logic [NUM_ROWS-1:0] ROW_RESET = 4'b1110;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    // One-cold pattern with the zero at position idx.
    function automatic logic [3:0] one_cold(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    function automatic logic single_low(input logic [NUM_COLS-1:0] c);
        return (c == 4'b1110) || (c == 4'b1101) || (c == 4'b1011) || (c == 4'b0111);
    endfunction

    function automatic logic [1:0] low_index(input logic [NUM_COLS-1:0] c);
        logic [1:0] idx;
        idx = 2'd0;
        case (c)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with asynchronous active-high reset to RESET_VAL.
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_p0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_p0 <= RESET_VAL;
            q       <= RESET_VAL;
        end else begin
            meta_p0 <= d;
            q       <= meta_p0;
        end
    end

endmodule

// File: rtl/hex_keypad_scanner.sv
// 4x4 active-low keypad scanner with debounce and a 4-digit entry shift register.
// Optional auto-repeat while a key is held: define KEYPAD_AUTOREPEAT_EN.
module hex_keypad_scanner
    import hex_keypad_pkg::*;
#(
    parameter int SCAN_CNT_WIDTH   = 14,
    parameter int DEBOUNCE_SAMPLES = 4,
    parameter int REPEAT_SAMPLES   = 64
) (
    input  logic                clk,
    input  logic                rst,
    output logic [NUM_ROWS-1:0] o_rows,
    input  logic [NUM_COLS-1:0] i_cols,
    input  logic                i_clear,
    output logic                o_key_valid,
    output logic [CODE_W-1:0]   o_key_code,
    output logic [15:0]         o_data
);

    localparam int DB_W = $clog2(DEBOUNCE_SAMPLES + 1);

    logic [NUM_COLS-1:0]       cols_s;
    logic [SCAN_CNT_WIDTH-1:0] dwell_cnt;
    logic [1:0]                row_idx;
    logic [1:0]                col_lat;
    logic [DB_W-1:0]           db_cnt;
    state_t                    state;

    logic              sample, valid, none, same, accept;
    logic [1:0]        col_idx;
    logic [CODE_W-1:0] acc_code;

    sync_2ff #(.WIDTH(NUM_COLS), .RESET_VAL(4'b1111)) u_col_sync (
        .clk (clk),
        .rst (rst),
        .d   (i_cols),
        .q   (cols_s)
    );

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RP_W = $clog2(REPEAT_SAMPLES + 1);
    logic [RP_W-1:0] rep_cnt;
`endif

    assign sample  = &dwell_cnt;
    assign valid   = single_low(cols_s);
    assign none    = &cols_s;
    assign col_idx = low_index(cols_s);
    assign same    = (cols_s == one_cold(col_lat));

    // Accept decision for the current sample; outputs register it one cycle later.
    always_comb begin
        accept   = 1'b0;
        acc_code = {row_idx, col_lat};
        if (sample) begin
            case (state)
                SCAN: begin
                    if (valid && DEBOUNCE_SAMPLES == 1) begin
                        accept   = 1'b1;
                        acc_code = {row_idx, col_idx};
                    end
                end
                DEBOUNCE: accept = same && (db_cnt == DB_W'(DEBOUNCE_SAMPLES - 1));
`ifdef KEYPAD_AUTOREPEAT_EN
                HELD:     accept = same && (rep_cnt == RP_W'(REPEAT_SAMPLES - 1));
`endif
                default:  accept = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell_cnt   <= '0;
            row_idx     <= 2'd0;
            o_rows      <= ROW_RESET;
            col_lat     <= 2'd0;
            db_cnt      <= '0;
            state       <= SCAN;
            o_key_valid <= 1'b0;
            o_key_code  <= '0;
            o_data      <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt     <= '0;
`endif
        end else begin
            dwell_cnt   <= dwell_cnt + 1'b1;
            o_key_valid <= accept;
            if (accept)
                o_key_code <= acc_code;
            if (i_clear)
                o_data <= accept ? {12'h000, acc_code} : 16'h0000;
            else if (accept)
                o_data <= {o_data[11:0], acc_code};

            if (sample) begin
                case (state)
                    SCAN: begin
                        if (valid) begin
                            col_lat <= col_idx;
                            db_cnt  <= (DEBOUNCE_SAMPLES == 1) ? DB_W'(0) : DB_W'(1);
                            state   <= (DEBOUNCE_SAMPLES == 1) ? HELD : DEBOUNCE;
                        end else begin
                            row_idx <= row_idx + 2'd1;
                            o_rows  <= one_cold(row_idx + 2'd1);
                        end
                    end
                    DEBOUNCE: begin
                        if (same) begin
                            if (accept) begin
                                db_cnt <= '0;
                                state  <= HELD;
                            end else begin
                                db_cnt <= db_cnt + 1'b1;
                            end
                        end else begin
                            db_cnt  <= '0;
                            state   <= SCAN;
                            row_idx <= row_idx + 2'd1;
                            o_rows  <= one_cold(row_idx + 2'd1);
                        end
                    end
                    HELD: begin
                        // Anything other than an all-high sample restarts the release count.
                        if (none) begin
                            if (db_cnt == DB_W'(DEBOUNCE_SAMPLES - 1)) begin
                                db_cnt  <= '0;
                                state   <= SCAN;
                                row_idx <= row_idx + 2'd1;
                                o_rows  <= one_cold(row_idx + 2'd1);
                            end else begin
                                db_cnt <= db_cnt + 1'b1;
                            end
                        end else begin
                            db_cnt <= '0;
                        end
                    end
                    default: state <= SCAN;
                endcase
`ifdef KEYPAD_AUTOREPEAT_EN
                if (state == HELD && same && !accept)
                    rep_cnt <= rep_cnt + 1'b1;
                else
                    rep_cnt <= '0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Scoreboard bench for hex_keypad_scanner with a 16-cycle dwell and 4-sample debounce.
module tb_hex_keypad_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  o_rows;
    logic [3:0]  i_cols;
    logic        i_clear = 1'b0;
    logic        o_key_valid;
    logic [3:0]  o_key_code;
    logic [15:0] o_data;

    always #5 clk = ~clk;

    hex_keypad_scanner #(
        .SCAN_CNT_WIDTH   (4),
        .DEBOUNCE_SAMPLES (4),
        .REPEAT_SAMPLES   (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .o_rows      (o_rows),
        .i_cols      (i_cols),
        .i_clear     (i_clear),
        .o_key_valid (o_key_valid),
        .o_key_code  (o_key_code),
        .o_data      (o_data)
    );

    // Keypad model: up to two pressed switches, each shorting a row to a column.
    logic k1_on = 1'b0, k2_on = 1'b0;
    int   k1_r = 0, k1_c = 0, k2_r = 0, k2_c = 0;

    always_comb begin
        i_cols = 4'b1111;
        if (k1_on && !o_rows[k1_r]) i_cols[k1_c] = 1'b0;
        if (k2_on && !o_rows[k2_r]) i_cols[k2_c] = 1'b0;
    end

    // Bench copy of the dwell position; equals the DUT dwell counter at each negedge.
    logic [3:0] phase;
    always @(posedge clk or posedge rst) begin
        if (rst) phase <= 4'd0;
        else     phase <= phase + 4'd1;
    end

    typedef struct {
        logic [3:0]  code;
        logic [15:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] model_data = 16'h0000;
    int          checks = 0;
    int          errors = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endfunction

    function automatic void expect_key(input logic [3:0] code, input logic clr);
        exp_t e;
        model_data = clr ? {12'h000, code} : {model_data[11:0], code};
        e.code = code;
        e.data = model_data;
        exp_q.push_back(e);
    endfunction

    // Monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && o_key_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: actual code %0h data %0h, required no pulse", o_key_code, o_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("key_code", {28'h0, o_key_code}, {28'h0, e.code});
                check("key_data", {16'h0, o_data}, {16'h0, e.data});
            end
        end
    end

    task automatic wait_row_mid(input logic [3:0] pat);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(o_rows == pat && phase == 4'd7) && n < 200);
        if (n >= 200) check("row_wait_timeout", {28'h0, o_rows}, {28'h0, pat});
    endtask

    task automatic wait_phase_end();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (phase != 4'd15 && n < 40);
    endtask

    task automatic press_key(input int r, input int c);
        logic [3:0] pat;
        pat = ~(4'b0001 << r);
        wait_row_mid(pat);
        expect_key(4'(r * 4 + c), 1'b0);
        k1_r = r; k1_c = c; k1_on = 1'b1;
        repeat (96) @(negedge clk);
        k1_on = 1'b0;
        repeat (96) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] cur;
        int         n;

        repeat (3) @(negedge clk);
        check("reset_rows", {28'h0, o_rows}, 32'hE);
        check("reset_valid", {31'h0, o_key_valid}, 32'h0);
        check("reset_code", {28'h0, o_key_code}, 32'h0);
        check("reset_data", {16'h0, o_data}, 32'h0);
        rst = 1'b0;

        // Idle rotation: one row step every 16 cycles.
        for (int i = 0; i < 4; i++) begin
            cur = o_rows;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (o_rows == cur && n < 40);
            check("row_dwell", n, 16);
            check("row_pattern", {28'h0, o_rows}, {28'h0, cur[2:0], cur[3]});
        end
        check("idle_data", {16'h0, o_data}, 32'h0);

        press_key(2, 1);
        press_key(3, 3);
        check("data_after_9F", {16'h0, o_data}, 32'h009F);

        // Bounce on row 0 / col 0: two short contacts before a stable press.
        for (int b = 0; b < 2; b++) begin
            wait_row_mid(4'b1110);
            k1_r = 0; k1_c = 0; k1_on = 1'b1;
            repeat (16) @(negedge clk);
            k1_on = 1'b0;
        end
        press_key(0, 0);

        press_key(0, 1);
        press_key(0, 2);
        press_key(0, 3);
        press_key(1, 0);
        press_key(1, 1);
        check("data_after_12345", {16'h0, o_data}, 32'h2345);

        // Clear coinciding with the accept of key 6.
        wait_row_mid(4'b1101);
        k1_r = 1; k1_c = 2; k1_on = 1'b1;
        for (int s = 0; s < 4; s++) wait_phase_end();
        expect_key(4'h6, 1'b1);
        i_clear = 1'b1;
        @(negedge clk);
        i_clear = 1'b0;
        repeat (64) @(negedge clk);
        k1_on = 1'b0;
        repeat (96) @(negedge clk);
        check("data_after_clear", {16'h0, o_data}, 32'h0006);

        // Two columns low on one row: invalid, rows keep rotating.
        wait_row_mid(4'b0111);
        k1_r = 3; k1_c = 0; k1_on = 1'b1;
        k2_r = 3; k2_c = 1; k2_on = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cur = o_rows;
            repeat (16) @(negedge clk);
            check("invalid_scan_rotates", {28'h0, o_rows}, {28'h0, cur[2:0], cur[3]});
        end
        k1_on = 1'b0;
        k2_on = 1'b0;

        // Reset in the middle of debounce, key still held.
        wait_row_mid(4'b1110);
        k1_r = 0; k1_c = 3; k1_on = 1'b1;
        repeat (32) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_rows", {28'h0, o_rows}, 32'hE);
        check("midrst_valid", {31'h0, o_key_valid}, 32'h0);
        check("midrst_code", {28'h0, o_key_code}, 32'h0);
        check("midrst_data", {16'h0, o_data}, 32'h0);
        model_data = 16'h0000;
        @(negedge clk);
        rst = 1'b0;
        expect_key(4'h3, 1'b0);
        repeat (96) @(negedge clk);
        k1_on = 1'b0;
        repeat (96) @(negedge clk);

        // Long hold of key A: auto-repeat every 8 samples only when enabled.
        wait_row_mid(4'b1011);
        k1_r = 2; k1_c = 2; k1_on = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
        for (int p = 0; p < 4; p++) expect_key(4'hA, 1'b0);
`else
        expect_key(4'hA, 1'b0);
`endif
        repeat (30 * 16) @(negedge clk);
        k1_on = 1'b0;
        repeat (96) @(negedge clk);

        repeat (20) @(negedge clk);
        check("pending_expectations", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
